preset_ce_sequencer: RTL
========================

# preset_ce_sequencer

Reset and clock-enable sequencer that sits directly upstream of the DFFPE/DFFCE register primitives. It turns the raw asynchronous PRESET into a clean, CLK-synchronised release for a downstream register bank, and supplies that bank with a periodic CE strobe. Assertion is asynchronous, release is synchronous, and a programmable hold interval separates release from first enable. Verilator-compatible like the rest of the Gowin primitive models.

## Interface
- SYNC_STAGES, 2: release synchroniser depth; legal range ≥ 2.
- HOLD_CYCLES, 16: cycles RST_OUT stays high after the synchroniser clears; legal range ≥ 1.
- CE_DIV, 4: CE_OUT period in cycles; 1 means CE_OUT is constantly high in RUN.

Ports:
- CLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- SRST  in  1  synchronous soft reset, active-high. Present only with PRESET_CE_SEQ_SRST_EN.
- RST_OUT  out  1  drives downstream PRESET. Asserts asynchronously, deasserts synchronously.
- CE_OUT  out  1  clock-enable strobe for the downstream bank.
- READY  out  1  high in the RUN state.

## Operation
- States: RST, HOLD, RUN.
- While PRESET is high:
  - All flops are forced asynchronously: sync chain to 1, state to RST, hold counter to HOLD_CYCLES-1, divider to 0.
  - Outputs: RST_OUT=1, CE_OUT=0, READY=0.
- Initial values for every flop equal these reset values (power-up model, no X).
- Sync chain: SYNC_STAGES flops preset to 1, shifting in 0 each CLK edge. `sync_clr` = last stage == 0.
- RST → HOLD: at the first edge where `sync_clr` is already 1. Counter is loaded with HOLD_CYCLES-1.
- HOLD: the counter decrements each edge. At the edge where counter == 0, go to RUN and clear the divider.
- RUN:
  - Divider increments modulo CE_DIV.
  - RST_OUT=0, READY=1.
  - CE_OUT is registered: ce_q <= (next_state==RUN) && (next_div==0).
- Counter and divider widths: $clog2 of their range, minimum 1 bit. The decrement never underflows, because the transition happens at 0.
- RST_OUT, READY and CE_OUT all come directly from flops; there is no combinational path except the async preset.

## Timing
- Edge numbering: edge 1 is the first CLK rising edge with PRESET low (S=SYNC_STAGES, H=HOLD_CYCLES).
- `sync_clr` rises after edge S. HOLD is entered at edge S+1. RUN is entered at edge S+H+1.
- With defaults, RST_OUT falls and READY rises after edge 19.
- First CE_OUT pulse is in the first RUN cycle, then one cycle high every CE_DIV cycles. Defaults give high after edges 19, 23, 27, …
- PRESET rising at any time, including mid-HOLD or in RUN: outputs return to reset values immediately, with no clock needed.
- PRESET pulse shorter than a clock period: still fully resets, and the sequence restarts from edge 1.
- PRESET falling coincident with a CLK edge: that edge does not count as edge 1.

## Configuration
- PRESET_CE_SEQ_SRST_EN defined:
  - SRST is sampled at each edge. If high in HOLD or RUN, the state goes to HOLD, the counter reloads H-1, and the divider clears.
  - RST_OUT=1, READY=0 and CE_OUT=0 after that edge.
  - Holding SRST high keeps the block in HOLD with the counter reloaded.
  - In RST state, SRST is ignored.
  - PRESET has priority over SRST.
- Macro undefined: SRST port absent and behaviour is identical to SRST tied 0.

## Structure
- Shared package gowin_seq_pkg holds:
  - State encoding: ST_RST=2'd0, ST_HOLD=2'd1, ST_RUN=2'd2 (2'd3 decodes as RST).
  - Helper function for counter width.
- Sub-module preset_sync holds the SYNC_STAGES-deep preset-to-1 release chain. Parameter: STAGES; ports: CLK, PRESET, SYNC_OUT. It is reusable by other primitives.

## Test plan
- Defaults, PRESET high for 3 cycles then low → RST_OUT=1 through edge 18, 0 after edge 19; READY matches; CE_OUT high after edges 19, 23, 27, low otherwise.
- PRESET asserted mid-cycle in RUN (between edges) → RST_OUT=1, READY=0, CE_OUT=0 before the next edge; release repeats the 19-edge sequence.
- CE_DIV=1, HOLD_CYCLES=1, SYNC_STAGES=2 → RUN and CE_OUT constant high after edge 4.
- PRESET glitch of 100 ps during HOLD → counter restarts; RUN is 19 edges after the glitch.
- With PRESET_CE_SEQ_SRST_EN, SRST high for one edge in RUN → RST_OUT=1 for 16 cycles, RUN again 16 edges after the SRST edge, first CE_OUT in that cycle.
- No clock, PRESET low from time 0 → all outputs hold initial values (RST_OUT=1, CE_OUT=0, READY=0), no X.

Source files
------------

// File: rtl/gowin_seq_pkg.sv
// rtl/gowin_seq_pkg.sv - shared state encoding and width helper for the Gowin reset/CE sequencers
`timescale 1ns/1ps
package gowin_seq_pkg;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/preset_sync.sv
// rtl/preset_sync.sv - preset-to-1 release synchroniser; SYNC_OUT stays high until STAGES clean edges pass
`timescale 1ns/1ps
module preset_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic PRESET,
   output logic SYNC_OUT
);

   // Stored as "released" bits so the all-zero power-up state equals the preset state.
   logic [STAGES-1:0] rel_q, rel_d;

   always_comb begin
      rel_d = {rel_q[STAGES-2:0], 1'b1};
   end

   always_ff @(posedge CLK or posedge PRESET) begin
      if (PRESET) begin
         rel_q <= '0;
      end else begin
         rel_q <= rel_d;
      end
   end

   assign SYNC_OUT = ~rel_q[STAGES-1];

endmodule

// File: rtl/preset_ce_sequencer.sv
// rtl/preset_ce_sequencer.sv - async-assert/sync-release reset plus CE strobe; soft reset under PRESET_CE_SEQ_SRST_EN
`timescale 1ns/1ps
module preset_ce_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int CE_DIV      = 4
) (
   input  logic CLK,
   input  logic PRESET,
`ifdef PRESET_CE_SEQ_SRST_EN
   input  logic SRST,
`endif
   output logic RST_OUT,
   output logic CE_OUT,
   output logic READY
);
   import gowin_seq_pkg::*;

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int DW = cnt_width(CE_DIV);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CE_DIV - 1);

   logic sync_set;
   logic sync_clr;
   logic srst;

   preset_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .CLK      (CLK),
      .PRESET   (PRESET),
      .SYNC_OUT (sync_set)
   );

   assign sync_clr = ~sync_set;

`ifdef PRESET_CE_SEQ_SRST_EN
   assign srst = SRST;
`else
   assign srst = 1'b0;
`endif

   seq_state_e    state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [DW-1:0] div_q, div_d;
   logic          rel_q, rel_d;
   logic          ready_q, ready_d;
   logic          ce_q, ce_d;

   // The hold counter counts elapsed HOLD cycles up to HOLD_CYCLES-1 (remaining = HOLD_LAST - count),
   // so every flop, including RST_OUT's complement rel_q, powers up in the reset state at zero.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      div_d      = div_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
               div_d   = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         ST_RUN: begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
         end
         default: begin
            if (sync_clr) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
      endcase
      if (srst && (state_q == ST_HOLD || state_q == ST_RUN)) begin
         state_d    = ST_HOLD;
         hold_cnt_d = '0;
         div_d      = '0;
      end
      rel_d   = (state_d == ST_RUN);
      ready_d = (state_d == ST_RUN);
      ce_d    = (state_d == ST_RUN) && (div_d == '0);
   end

   always_ff @(posedge CLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= ST_RST;
         hold_cnt_q <= '0;
         div_q      <= '0;
         rel_q      <= 1'b0;
         ready_q    <= 1'b0;
         ce_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         div_q      <= div_d;
         rel_q      <= rel_d;
         ready_q    <= ready_d;
         ce_q       <= ce_d;
      end
   end

   assign RST_OUT = ~rel_q;
   assign READY   = ready_q;
   assign CE_OUT  = ce_q;

endmodule
